conv_mac_engine: RTL and testbench

//  Multi-lane signed-integer convolution engine for one output pixel: dot product of a D*S*S image window and filter.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_lane_mac.sv | 26 ++
 rtl/conv_mac_engine.sv | 145 ++++++++++++++
 tb/tb_conv_mac_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the convolution MAC engine.
// Beat count, counter width and lane padding are derived here from N and LANES.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned conv_beats(input int unsigned n, input int unsigned lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  function automatic int unsigned beat_cnt_width(input int unsigned beats);
    return (beats > 1) ? clog2(beats) : 1;
  endfunction

  // Operands are zero-extended to a whole number of beats, so lanes past N multiply by 0.
  function automatic int unsigned padded_elems(input int unsigned n, input int unsigned lanes);
    return conv_beats(n, lanes) * lanes;
  endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// Combinational LANES-wide signed multiply and adder tree.
// Each full-width product is sign-extended to ACC_WIDTH; the sum wraps.
module conv_lane_mac #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned LANES      = 1
) (
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]        sum_c
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc;

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int l = 0; l < LANES; l++) begin
      prod = $signed(a[l*DATA_WIDTH +: DATA_WIDTH]) * $signed(b[l*DATA_WIDTH +: DATA_WIDTH]);
      acc  = acc + ACC_WIDTH'(prod);
    end
    sum_c = acc;
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Multi-lane signed dot-product engine for one output pixel with a valid/ready result.
// Optional build macro CONV_RELU_EN clamps negative results to zero at OUT entry.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned D          = 1,
  parameter int unsigned S          = 5,
  parameter int unsigned LANES      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           ready_in,
  input  logic [D*S*S*DATA_WIDTH-1:0]    img,
  input  logic [D*S*S*DATA_WIDTH-1:0]    fit,
  output logic [ACC_WIDTH-1:0]           res,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           busy
);

  localparam int unsigned N     = D * S * S;
  localparam int unsigned BEATS = conv_beats(N, LANES);
  localparam int unsigned BW    = beat_cnt_width(BEATS);
  localparam int unsigned PAD_N = padded_elems(N, LANES);
  localparam int unsigned OPW   = N * DATA_WIDTH;
  localparam int unsigned PADW  = PAD_N * DATA_WIDTH;
  localparam int unsigned LW    = LANES * DATA_WIDTH;

  state_e               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] res_q, res_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;
  logic [OPW-1:0]       img_q, img_d;
  logic [OPW-1:0]       fit_q, fit_d;

  logic [PADW-1:0]      img_pad_c, fit_pad_c;
  logic [LW-1:0]        lane_img_c, lane_fit_c;
  logic [ACC_WIDTH-1:0] lane_sum_c;
  logic [ACC_WIDTH-1:0] sum_next_c;
  logic                 accept_c;

  assign img_pad_c = PADW'(img_q);
  assign fit_pad_c = PADW'(fit_q);

  // Beat-indexed operand mux feeding the lane MAC.
  always_comb begin
    lane_img_c = '0;
    lane_fit_c = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) begin
        lane_img_c = img_pad_c[b*LW +: LW];
        lane_fit_c = fit_pad_c[b*LW +: LW];
      end
    end
  end

  conv_lane_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .LANES      (LANES)
  ) u_lane_mac (
    .a     (lane_img_c),
    .b     (lane_fit_c),
    .sum_c (lane_sum_c)
  );

  assign ready_in   = (state_q == IDLE) || ((state_q == OUT) && res_ready);
  assign accept_c   = start && ready_in;
  assign sum_next_c = acc_q + lane_sum_c;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    img_d       = img_q;
    fit_d       = fit_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        acc_d = sum_next_c;
        if (beat_q == BW'(BEATS - 1)) begin
          state_d     = OUT;
          res_valid_d = 1'b1;
`ifdef CONV_RELU_EN
          res_d       = sum_next_c[ACC_WIDTH-1] ? '0 : sum_next_c;
`else
          res_d       = sum_next_c;
`endif
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new job may be taken from IDLE or on the same edge an OUT result drains.
    if (accept_c) begin
      state_d = RUN;
      beat_d  = '0;
      acc_d   = '0;
      img_d   = img;
      fit_d   = fit;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      img_q       <= '0;
      fit_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      img_q       <= img_d;
      fit_q       <= fit_d;
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: LANES=1 and LANES=4 instances checked against a dot-product model.
module tb_conv_mac_engine;

  localparam int DW      = 16;
  localparam int AW      = 40;
  localparam int D       = 1;
  localparam int S       = 5;
  localparam int N       = D * S * S;
  localparam int LANES_A = 1;
  localparam int LANES_B = 4;

  logic clk = 1'b0;
  logic rst;
  logic            start_v     [2];
  logic            rdy_v       [2];
  logic [N*DW-1:0] img_v       [2];
  logic [N*DW-1:0] fit_v       [2];
  logic            ready_in_v  [2];
  logic [AW-1:0]   res_v       [2];
  logic            res_valid_v [2];
  logic            busy_v      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_mac_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .D(D), .S(S), .LANES(LANES_A)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .ready_in(ready_in_v[0]),
    .img(img_v[0]), .fit(fit_v[0]), .res(res_v[0]), .res_valid(res_valid_v[0]),
    .res_ready(rdy_v[0]), .busy(busy_v[0])
  );

  conv_mac_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .D(D), .S(S), .LANES(LANES_B)) u_dut_l4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .ready_in(ready_in_v[1]),
    .img(img_v[1]), .fit(fit_v[1]), .res(res_v[1]), .res_valid(res_valid_v[1]),
    .res_ready(rdy_v[1]), .busy(busy_v[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input int u);
    return (u == 0) ? (N + LANES_A - 1) / LANES_A : (N + LANES_B - 1) / LANES_B;
  endfunction

  // Reference: plain signed dot product, optional clamp, truncated to the result width.
  function automatic logic [AW-1:0] ref_dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++)
      s += longint'($signed(a[k*DW +: DW])) * longint'($signed(b[k*DW +: DW]));
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return AW'(s);
  endfunction

  function automatic logic [N*DW-1:0] fill(input int val);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(val);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] ramp();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(k);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a job, optionally scramble inputs and re-pulse start during RUN, wait for the result.
  task automatic run_to_valid(input int u, input string tag, input logic [N*DW-1:0] a,
                              input logic [N*DW-1:0] b, input bit scramble);
    int lat;
    img_v[u]   = a;
    fit_v[u]   = b;
    start_v[u] = 1'b1;
    rdy_v[u]   = 1'b0;
    tick();
    lat = 1;
    start_v[u] = scramble;
    if (scramble) begin
      img_v[u] = '0;
      fit_v[u] = '0;
    end
    chk({tag, "_busy"}, 64'(busy_v[u]), 64'd1);
    chk({tag, "_ready_in"}, 64'(ready_in_v[u]), 64'd0);
    while (!res_valid_v[u] && lat < 200) begin
      tick();
      lat++;
    end
    start_v[u] = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(beats_of(u) + 1));
    chk({tag, "_res"}, 64'(res_v[u]), 64'(ref_dot(a, b)));
  endtask

  task automatic collect(input int u, input string tag);
    rdy_v[u] = 1'b1;
    tick();
    rdy_v[u] = 1'b0;
    chk({tag, "_drain_valid"}, 64'(res_valid_v[u]), 64'd0);
    chk({tag, "_drain_busy"}, 64'(busy_v[u]), 64'd0);
    chk({tag, "_drain_ready"}, 64'(ready_in_v[u]), 64'd1);
  endtask

  task automatic run_job(input int u, input string tag, input logic [N*DW-1:0] a,
                         input logic [N*DW-1:0] b);
    run_to_valid(u, tag, a, b, 1'b0);
    collect(u, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] a, b, a2, b2;
    logic [AW-1:0]   exp;
    int              lat;

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0;
      rdy_v[u]   = 1'b0;
      img_v[u]   = '0;
      fit_v[u]   = '0;
    end
    repeat (2) tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst_res", 64'(res_v[u]), 64'd0);
      chk("rst_valid", 64'(res_valid_v[u]), 64'd0);
      chk("rst_busy", 64'(busy_v[u]), 64'd0);
      chk("rst_ready_in", 64'(ready_in_v[u]), 64'd1);
    end
    rst = 1'b0;
    tick();

    run_job(0, "t1_ones", fill(1), fill(2));
    run_job(1, "t2_ramp", ramp(), fill(1));
    run_job(0, "t3_neg_l1", fill(-3), fill(7));
    run_job(1, "t3_neg_l4", fill(-3), fill(7));
    run_job(0, "t_extreme", fill(-32768), fill(-32768));

    for (int i = 0; i < 4; i++)
      for (int u = 0; u < 2; u++)
        run_job(u, "rnd", rand_vec(), rand_vec());

    // Backpressure on the 4-lane unit, then a back-to-back job on the draining edge.
    a = rand_vec();
    b = rand_vec();
    exp = ref_dot(a, b);
    run_to_valid(1, "t4_first", a, b, 1'b0);
    for (int i = 0; i < 10; i++) begin
      start_v[1] = 1'b1;
      img_v[1]   = rand_vec();
      fit_v[1]   = rand_vec();
      tick();
      chk("t4_hold_valid", 64'(res_valid_v[1]), 64'd1);
      chk("t4_hold_res", 64'(res_v[1]), 64'(exp));
      chk("t4_hold_ready_in", 64'(ready_in_v[1]), 64'd0);
    end
    a2 = rand_vec();
    b2 = rand_vec();
    img_v[1] = a2;
    fit_v[1] = b2;
    rdy_v[1] = 1'b1;
    #1;
    chk("t4_ready_in_comb", 64'(ready_in_v[1]), 64'd1);
    tick();
    lat = 1;
    start_v[1] = 1'b0;
    rdy_v[1]   = 1'b0;
    chk("t4_b2b_valid_drop", 64'(res_valid_v[1]), 64'd0);
    chk("t4_b2b_busy", 64'(busy_v[1]), 64'd1);
    while (!res_valid_v[1] && lat < 200) begin
      tick();
      lat++;
    end
    chk("t4_b2b_lat", 64'(lat), 64'(beats_of(1) + 1));
    chk("t4_b2b_res", 64'(res_v[1]), 64'(ref_dot(a2, b2)));
    collect(1, "t4_b2b");

    // Inputs zeroed and start re-pulsed mid-RUN; the latched operands decide the result.
    run_to_valid(0, "t5_latch", rand_vec(), rand_vec(), 1'b1);
    collect(0, "t5_latch");
    run_to_valid(1, "t5_latch4", rand_vec(), rand_vec(), 1'b1);
    collect(1, "t5_latch4");

    // Reset during RUN beat 3 aborts the job immediately.
    img_v[0]   = rand_vec();
    fit_v[0]   = rand_vec();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_res", 64'(res_v[0]), 64'd0);
    chk("t6_rst_valid", 64'(res_valid_v[0]), 64'd0);
    chk("t6_rst_busy", 64'(busy_v[0]), 64'd0);
    chk("t6_rst_ready_in", 64'(ready_in_v[0]), 64'd1);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("t6_no_stale_valid", 64'(res_valid_v[0]), 64'd0);
    run_job(0, "t6_after", rand_vec(), rand_vec());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
